// File: rtl/dtree_seq_pkg.sv
// Shared types and constants for the sequential decision-tree evaluator.
// Holds the node record layout, the FSM state type and the default node table.
package dtree_seq_pkg;

   localparam int unsigned DT_N_FEAT        = 5;
   localparam int unsigned DT_FEAT_W        = 8;
   localparam int unsigned DT_CLASS_W       = 5;
   localparam int unsigned DT_N_NODES       = 16;
   localparam int unsigned DT_NODE_AW       = 4;
   localparam int unsigned DT_DEFAULT_CLASS = 0;
   localparam int unsigned DT_SEL_W         = 3;
   localparam int unsigned DT_SHIFT_W       = 3;

   // One node of the tree; leaf nodes only use leaf_class.
   typedef struct packed {
      logic                    is_leaf;
      logic [DT_SEL_W-1:0]     feat_sel;
      logic [DT_SHIFT_W-1:0]   shift;
      logic [DT_FEAT_W-1:0]    thr;
      logic [DT_NODE_AW-1:0]   t_idx;
      logic [DT_NODE_AW-1:0]   f_idx;
      logic [DT_CLASS_W-1:0]   leaf_class;
   } node_t;

   typedef node_t [DT_N_NODES-1:0] node_table_t;

   typedef enum logic [1:0] {
      StIdle,
      StEval,
      StDone
   } state_e;

   function automatic node_t mk_leaf(input int unsigned cls);
      node_t n;
      n            = '0;
      n.is_leaf    = 1'b1;
      n.leaf_class = DT_CLASS_W'(cls);
      return n;
   endfunction

   function automatic node_t mk_node(input int unsigned feat, input int unsigned shift,
                                     input int unsigned thr, input int unsigned t_idx,
                                     input int unsigned f_idx);
      node_t n;
      n          = '0;
      n.feat_sel = DT_SEL_W'(feat);
      n.shift    = DT_SHIFT_W'(shift);
      n.thr      = DT_FEAT_W'(thr);
      n.t_idx    = DT_NODE_AW'(t_idx);
      n.f_idx    = DT_NODE_AW'(f_idx);
      return n;
   endfunction

   // Reference classifier; every unused slot is a leaf reporting the default class.
   function automatic node_table_t default_table();
      node_table_t tbl;
      for (int unsigned i = 0; i < DT_N_NODES; i++) begin
         tbl[DT_NODE_AW'(i)] = mk_leaf(DT_DEFAULT_CLASS);
      end
      tbl[DT_NODE_AW'(0)] = mk_node(4, 6, 0, 1, 2);
      tbl[DT_NODE_AW'(1)] = mk_leaf(7);
      tbl[DT_NODE_AW'(2)] = mk_node(4, 5, 1, 3, 4);
      tbl[DT_NODE_AW'(3)] = mk_leaf(24);
      tbl[DT_NODE_AW'(4)] = mk_leaf(12);
      return tbl;
   endfunction

   localparam node_table_t NODE_TABLE = default_table();

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node table lookup for the decision-tree evaluator.
// Any index not covered by the table reads back as a default-class leaf.
module dtree_node_rom
   import dtree_seq_pkg::*;
#(
   parameter node_table_t TABLE     = NODE_TABLE,
   parameter int unsigned DEF_CLASS = DT_DEFAULT_CLASS
) (
   input  logic [DT_NODE_AW-1:0] node_idx_i,
   output node_t                 node_o
);

   // Decode the node index into its record.
   always_comb begin
      node_o = mk_leaf(DEF_CLASS);
      case (node_idx_i)
         4'd0:    node_o = TABLE[0];
         4'd1:    node_o = TABLE[1];
         4'd2:    node_o = TABLE[2];
         4'd3:    node_o = TABLE[3];
         4'd4:    node_o = TABLE[4];
         4'd5:    node_o = TABLE[5];
         4'd6:    node_o = TABLE[6];
         4'd7:    node_o = TABLE[7];
         4'd8:    node_o = TABLE[8];
         4'd9:    node_o = TABLE[9];
         4'd10:   node_o = TABLE[10];
         4'd11:   node_o = TABLE[11];
         4'd12:   node_o = TABLE[12];
         4'd13:   node_o = TABLE[13];
         4'd14:   node_o = TABLE[14];
         4'd15:   node_o = TABLE[15];
         default: node_o = mk_leaf(DEF_CLASS);
      endcase
   end

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks the node table one node per clock
// with a single shared threshold comparator, then presents the class.
// Optional build macro DTREE_STEPS_EN adds out_steps (internal nodes traversed).
module dtree_seq_eval
   import dtree_seq_pkg::*;
#(
   parameter int unsigned N_FEAT        = DT_N_FEAT,
   parameter int unsigned FEAT_W        = DT_FEAT_W,
   parameter int unsigned CLASS_W       = DT_CLASS_W,
   parameter int unsigned N_NODES       = DT_N_NODES,
   parameter int unsigned NODE_AW       = DT_NODE_AW,
   parameter int unsigned DEFAULT_CLASS = DT_DEFAULT_CLASS,
   parameter node_table_t TABLE         = NODE_TABLE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_FEAT*FEAT_W-1:0]  in_feat,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CLASS_W-1:0]        out_class,
   output logic                      out_err
`ifdef DTREE_STEPS_EN
  ,output logic [NODE_AW-1:0]        out_steps
`endif
);

   state_e                     state_q, state_d;
   logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;
   logic [NODE_AW-1:0]         node_idx_q, node_idx_d;
   logic [NODE_AW-1:0]         step_cnt_q, step_cnt_d;
   logic [CLASS_W-1:0]         class_q, class_d;
   logic                       err_q, err_d;
   logic                       valid_q, valid_d;
`ifdef DTREE_STEPS_EN
   logic [NODE_AW-1:0]         steps_q, steps_d;
`endif

   node_t                      node;
   logic [FEAT_W-1:0]          feat_val;
   logic [FEAT_W-1:0]          feat_shr;
   logic                       feat_ok;
   logic                       step_limit;
   logic [NODE_AW-1:0]         child;

   dtree_node_rom #(
      .TABLE     (TABLE),
      .DEF_CLASS (DEFAULT_CLASS)
   ) u_rom (
      .node_idx_i (node_idx_q),
      .node_o     (node)
   );

   // Shared comparator: select the feature, shift it down, compare to the threshold.
   always_comb begin
      feat_val = '0;
      for (int unsigned k = 0; k < N_FEAT; k++) begin
         if (node.feat_sel == DT_SEL_W'(k)) begin
            feat_val = feat_q[k*FEAT_W +: FEAT_W];
         end
      end
      feat_ok    = (32'(node.feat_sel) < N_FEAT);
      feat_shr   = feat_val >> node.shift;
      child      = (feat_shr <= node.thr) ? node.t_idx : node.f_idx;
      step_limit = (step_cnt_q == NODE_AW'(N_NODES - 1));
   end

   // Next-state logic for the walk FSM and result registers.
   always_comb begin
      state_d    = state_q;
      feat_d     = feat_q;
      node_idx_d = node_idx_q;
      step_cnt_d = step_cnt_q;
      class_d    = class_q;
      err_d      = err_q;
      valid_d    = 1'b0;
`ifdef DTREE_STEPS_EN
      steps_d    = steps_q;
`endif
      in_ready   = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               feat_d     = in_feat;
               node_idx_d = '0;
               step_cnt_d = '0;
               state_d    = StEval;
            end
         end

         StEval: begin
            if (node.is_leaf) begin
               class_d = node.leaf_class;
               err_d   = 1'b0;
`ifdef DTREE_STEPS_EN
               steps_d = step_cnt_q;
`endif
               state_d = StDone;
            end else if (step_limit || !feat_ok) begin
               // Bad table (loop or out-of-range feature): abort with the default class.
               class_d = CLASS_W'(DEFAULT_CLASS);
               err_d   = 1'b1;
`ifdef DTREE_STEPS_EN
               steps_d = step_cnt_q;
`endif
               state_d = StDone;
            end else begin
               node_idx_d = child;
               step_cnt_d = step_cnt_q + 1'b1;
            end
         end

         StDone: begin
            // out_valid comes from a flop, so it rises one cycle after the result lands.
            valid_d = 1'b1;
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         feat_q     <= '0;
         node_idx_q <= '0;
         step_cnt_q <= '0;
         class_q    <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
`ifdef DTREE_STEPS_EN
         steps_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         feat_q     <= feat_d;
         node_idx_q <= node_idx_d;
         step_cnt_q <= step_cnt_d;
         class_q    <= class_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
`ifdef DTREE_STEPS_EN
         steps_q    <= steps_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign out_class = class_q;
   assign out_err   = err_q;
`ifdef DTREE_STEPS_EN
   assign out_steps = steps_q;
`endif

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Self-checking bench for dtree_seq_eval: a default-table instance and a
// self-looping-table instance share stimulus and are checked against a
// transaction-level tree-walk model every cycle.
module tb_dtree_seq_eval;
   import dtree_seq_pkg::*;

   function automatic node_table_t loop_table();
      node_table_t t;
      for (int i = 0; i < 16; i++) t[4'(i)] = mk_leaf(0);
      t[4'(0)] = mk_node(4, 6, 0, 0, 0);
      return t;
   endfunction
   localparam node_table_t LOOP_TABLE = loop_table();

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [39:0] in_feat;
   logic [1:0]  in_ready_v;
   logic [1:0]  out_valid_v;
   logic [1:0]  out_err_v;
   logic [4:0]  out_class_v [2];
`ifdef DTREE_STEPS_EN
   logic [3:0]  out_steps_v [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model tables: [instance][node]
   int t_leaf [2][16];
   int t_cls  [2][16];
   int t_feat [2][16];
   int t_shift[2][16];
   int t_thr  [2][16];
   int t_t    [2][16];
   int t_f    [2][16];

   // Model transaction state: 0 idle, 1 walking, 2 presenting
   int m_phase[2] = '{0, 0};
   int m_cnt  [2] = '{0, 0};
   int m_cls  [2] = '{0, 0};
   int m_err  [2] = '{0, 0};
   int m_steps[2] = '{0, 0};

   dtree_seq_eval u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[0]),
      .in_feat   (in_feat),
      .out_valid (out_valid_v[0]),
      .out_ready (out_ready),
      .out_class (out_class_v[0]),
      .out_err   (out_err_v[0])
`ifdef DTREE_STEPS_EN
     ,.out_steps (out_steps_v[0])
`endif
   );

   dtree_seq_eval #(
      .TABLE (LOOP_TABLE)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[1]),
      .in_feat   (in_feat),
      .out_valid (out_valid_v[1]),
      .out_ready (out_ready),
      .out_class (out_class_v[1]),
      .out_err   (out_err_v[1])
`ifdef DTREE_STEPS_EN
     ,.out_steps (out_steps_v[1])
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void set_node(input int s, input int n, input int feat, input int shift,
                                    input int thr, input int t, input int f);
      t_leaf[s][n] = 0; t_feat[s][n] = feat; t_shift[s][n] = shift;
      t_thr[s][n] = thr; t_t[s][n] = t; t_f[s][n] = f;
   endfunction

   function automatic void set_tables();
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < 16; n++) begin
            t_leaf[s][n] = 1; t_cls[s][n] = 0; t_feat[s][n] = 0; t_shift[s][n] = 0;
            t_thr[s][n] = 0; t_t[s][n] = 0; t_f[s][n] = 0;
         end
      set_node(0, 0, 4, 6, 0, 1, 2);
      t_cls[0][1] = 7;
      set_node(0, 2, 4, 5, 1, 3, 4);
      t_cls[0][3] = 24;
      t_cls[0][4] = 12;
      set_node(1, 0, 4, 6, 0, 0, 0);
   endfunction

   // Walk the tree by its rules: class, error flag, internal nodes passed.
   function automatic void walk(input int s, input logic [39:0] fv,
                                output int cls, output int err, output int steps);
      int idx;
      int v;
      idx = 0; cls = 0; err = 1; steps = 15;
      for (int k = 0; k < 16; k++) begin
         if (t_leaf[s][idx] != 0) begin
            cls = t_cls[s][idx]; err = 0; steps = k;
            return;
         end
         if (t_feat[s][idx] >= 5 || k == 15) begin
            cls = 0; err = 1; steps = k;
            return;
         end
         v   = int'(fv[t_feat[s][idx]*8 +: 8]) >> t_shift[s][idx];
         idx = (v <= t_thr[s][idx]) ? t_t[s][idx] : t_f[s][idx];
      end
   endfunction

   // Transaction model: result appears steps+2 edges after acceptance.
   always @(posedge clk) begin
      int c, e, s;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_phase[i] <= 0;
         end else begin
            case (m_phase[i])
               0: if (in_valid) begin
                  walk(i, in_feat, c, e, s);
                  m_cls[i]   <= c;
                  m_err[i]   <= e;
                  m_steps[i] <= s;
                  m_cnt[i]   <= s + 2;
                  m_phase[i] <= 1;
               end
               1: begin
                  if (m_cnt[i] == 1) m_phase[i] <= 2;
                  m_cnt[i] <= m_cnt[i] - 1;
               end
               2: if (out_ready) m_phase[i] <= 0;
               default: m_phase[i] <= 0;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.in_ready", i), 32'(in_ready_v[i]), 32'(m_phase[i] == 0));
            chk($sformatf("dut%0d.out_valid", i), 32'(out_valid_v[i]), 32'(m_phase[i] == 2));
            if (m_phase[i] == 2) begin
               chk($sformatf("dut%0d.out_class", i), 32'(out_class_v[i]), m_cls[i]);
               chk($sformatf("dut%0d.out_err", i), 32'(out_err_v[i]), m_err[i]);
`ifdef DTREE_STEPS_EN
               chk($sformatf("dut%0d.out_steps", i), 32'(out_steps_v[i]), m_steps[i]);
`endif
            end
         end
      end
   end

   function automatic logic [39:0] vec(input logic [7:0] f4);
      return {f4, 32'hA53C_9917};
   endfunction

   task automatic pin(input int s, input logic [39:0] v, input int ec, input int ee, input int es);
      int c, e, st;
      walk(s, v, c, e, st);
      chk("model.class", c, ec);
      chk("model.err", e, ee);
      chk("model.steps", st, es);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(m_phase[0] == 0 && m_phase[1] == 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
      end
   endtask

   task automatic reset_checks(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.dut%0d.in_ready", tag, i), 32'(in_ready_v[i]), 1);
         chk($sformatf("%s.dut%0d.out_valid", tag, i), 32'(out_valid_v[i]), 0);
         chk($sformatf("%s.dut%0d.out_class", tag, i), 32'(out_class_v[i]), 0);
         chk($sformatf("%s.dut%0d.out_err", tag, i), 32'(out_err_v[i]), 0);
`ifdef DTREE_STEPS_EN
         chk($sformatf("%s.dut%0d.out_steps", tag, i), 32'(out_steps_v[i]), 0);
`endif
      end
   endtask

   task automatic run_vec(input logic [39:0] v, input int hold, input bit scramble,
                          input int exp_a, input int exp_b);
      int la, lb;
      wait_idle();
      in_feat   = v;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      la = -1;
      lb = -1;
      for (int e = 1; e <= 40; e++) begin
         if (scramble) in_feat = {8'($urandom), 32'($urandom)};
         @(posedge clk); #1;
         if (out_valid_v[0] && la < 0) la = e;
         if (out_valid_v[1] && lb < 0) lb = e;
         if (la >= 0 && lb >= 0) break;
      end
      chk("latency.dut0", la, exp_a);
      chk("latency.dut1", lb, exp_b);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         out_ready = 1'b1;
      end
      wait_idle();
   endtask

   initial begin
      set_tables();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_feat   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      reset_checks("reset");

      // Hand-derived model expectations.
      pin(0, vec(8'h30), 7, 0, 1);
      pin(0, vec(8'h3F), 7, 0, 1);
      pin(0, vec(8'h50), 12, 0, 2);
      pin(0, vec(8'hF0), 12, 0, 2);
      pin(1, vec(8'h30), 0, 1, 15);

      run_vec(vec(8'h30), 0, 1'b0, 3, 17);
      run_vec(vec(8'h50), 0, 1'b0, 4, 17);
      run_vec(vec(8'hF0), 0, 1'b0, 4, 17);
      run_vec(vec(8'h3F), 0, 1'b0, 3, 17);
      // Consumer stalls for 10 cycles with results pending.
      run_vec(vec(8'h30), 10, 1'b0, 3, 17);
      // Inputs wander after acceptance.
      run_vec(vec(8'h50), 0, 1'b1, 4, 17);
      run_vec(vec(8'h20), 0, 1'b1, 3, 17);

      // Reset during the walk.
      wait_idle();
      in_feat   = vec(8'hF0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      reset_checks("rst_eval");
      run_vec(vec(8'h30), 0, 1'b0, 3, 17);

      // Reset while a result is being presented.
      wait_idle();
      in_feat   = vec(8'h50);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      reset_checks("rst_done");
      run_vec(vec(8'hF0), 0, 1'b0, 4, 17);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
